// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage of the single-cycle core. It holds the PC and fetches one
// instruction word per execute step from instruction memory over a
// request/ready handshake. It then presents the word to the main decoder and
// computes the next PC from the decoder's Branch/Jump flags and the ALU Zero
// flag. A watchdog flags an instruction memory that never answers.
//
// Ports
//   CLK          clock, all state updates on the rising edge
//   RST          synchronous, active-high reset
//   imem_req     fetch request (high while in FETCH)
//   imem_addr    fetch address, always equal to pc
//   imem_ready   memory returned data on imem_rdata this cycle
//   imem_rdata   instruction word from memory
//   instr        latched instruction word for the decoder
//   instr_valid  instr is valid and being executed (high while in EXEC)
//   exec_done    datapath finished the current instruction; commit next PC
//   Branch       branch flag from the main decoder
//   Jump         jump flag from the main decoder
//   Zero         ALU zero flag
//   pc           current PC
//   fault        watchdog tripped; sticky until reset
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          TIMEOUT  = 16,
   parameter int          CNT_W    = 8
) (
   input  logic        CLK,
   input  logic        RST,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   input  logic        exec_done,
   input  logic        Branch,
   input  logic        Jump,
   input  logic        Zero,
   output logic [31:0] pc,
   output logic        fault
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2,
      ST_FAULT = 2'd3
   } state_t;

   // A zero TIMEOUT disables the watchdog entirely; the counter then stays at 0.
   localparam bit               WD_EN    = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WD_EN ? TIMEOUT - 1 : 0);

   state_t            state;
   logic [CNT_W-1:0]  wd_cnt;
   logic [31:0]       next_pc;

   // Next-PC selection. Jump wins over a taken branch; all sums wrap mod 2^32.
   function automatic logic [31:0] calc_next_pc(input logic [31:0] cur_pc,
                                                input logic [31:0] cur_instr,
                                                input logic        br,
                                                input logic        jmp,
                                                input logic        zf);
      logic        [31:0] pc4;
      logic signed [31:0] br_off;
      pc4    = cur_pc + 32'd4;
      br_off = {{14{cur_instr[15]}}, cur_instr[15:0], 2'b00};
      if (jmp)
         calc_next_pc = {pc4[31:28], cur_instr[25:0], 2'b00};
      else if (br && zf)
         calc_next_pc = pc4 + $unsigned(br_off);
      else
         calc_next_pc = pc4;
   endfunction

   assign next_pc = calc_next_pc(pc, instr, Branch, Jump, Zero);

   // Handshake-facing outputs are decoded from registered state only, so no
   // input reaches an output combinationally.
   assign imem_req    = (state == ST_FETCH);
   assign instr_valid = (state == ST_EXEC);
   assign imem_addr   = pc;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state  <= ST_IDLE;
         pc     <= RESET_PC;
         instr  <= 32'h0000_0000;
         fault  <= 1'b0;
         wd_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               state <= ST_FETCH;
            end
            ST_FETCH: begin
               if (imem_ready) begin
                  instr  <= imem_rdata;
                  wd_cnt <= '0;
                  state  <= ST_EXEC;
               end else if (WD_EN) begin
                  wd_cnt <= wd_cnt + 1'b1;
                  // Counter holds the number of unanswered cycles already seen,
                  // so reaching TIMEOUT-1 here means this is cycle TIMEOUT.
                  if (wd_cnt == CNT_LAST) begin
                     state <= ST_FAULT;
                     fault <= 1'b1;
                  end
               end
            end
            ST_EXEC: begin
               if (exec_done) begin
                  pc    <= next_pc;
                  state <= ST_FETCH;
               end
            end
            ST_FAULT: begin
               state <= ST_FAULT;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic imem_ready = 1'b0;
   logic exec_done = 1'b0;
   logic Branch = 1'b0, Jump = 1'b0, Zero = 1'b0;
   logic hj = 1'b0;
   logic zero_l = 1'b0;

   int errors = 0;
   int checks = 0;

   always #5 CLK = ~CLK;

   // Memory image shared by all three units.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: mem_word = 32'h8C01_0000;  // lw
         32'h0000_0004: mem_word = 32'h0022_1820;  // add
         32'h0000_0008: mem_word = 32'hAC03_0004;  // sw
         32'h0000_000C: mem_word = 32'h0000_0020;  // plain
         32'h0000_0010: mem_word = 32'h1000_FFFE;  // beq imm=-2
         32'h0000_0014: mem_word = 32'h0800_0040;  // j 0x100 (imm field 0x40)
         32'h0000_0100: mem_word = 32'h0000_0020;
         32'h4000_0020: mem_word = 32'h0800_0100;  // j target 26'h100
         32'hFFFF_FFFC: mem_word = 32'h0000_0020;
         default:       mem_word = a ^ 32'h1234_0000;
      endcase
   endfunction

   // Main unit: RESET_PC=0, TIMEOUT=16
   logic m_req, m_vld, m_fault;
   logic [31:0] m_addr, m_instr, m_pc, m_rdata;
   assign m_rdata = mem_word(m_addr);
   instr_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(16), .CNT_W(8)) u_main (
      .CLK(CLK), .RST(RST), .imem_req(m_req), .imem_addr(m_addr),
      .imem_ready(imem_ready), .imem_rdata(m_rdata), .instr(m_instr),
      .instr_valid(m_vld), .exec_done(exec_done), .Branch(Branch),
      .Jump(Jump), .Zero(Zero), .pc(m_pc), .fault(m_fault));

   // High-PC unit: RESET_PC=0x4000_0020, watchdog disabled
   logic h_req, h_vld, h_fault;
   logic [31:0] h_addr, h_instr, h_pc, h_rdata;
   assign h_rdata = mem_word(h_addr);
   instr_fetch_unit #(.RESET_PC(32'h4000_0020), .TIMEOUT(0), .CNT_W(8)) u_hi (
      .CLK(CLK), .RST(RST), .imem_req(h_req), .imem_addr(h_addr),
      .imem_ready(imem_ready), .imem_rdata(h_rdata), .instr(h_instr),
      .instr_valid(h_vld), .exec_done(exec_done), .Branch(zero_l),
      .Jump(hj), .Zero(zero_l), .pc(h_pc), .fault(h_fault));

   // Wrap unit: RESET_PC=0xFFFF_FFFC, TIMEOUT=16
   logic w_req, w_vld, w_fault;
   logic [31:0] w_addr, w_instr, w_pc, w_rdata;
   assign w_rdata = mem_word(w_addr);
   instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT(16), .CNT_W(8)) u_wrap (
      .CLK(CLK), .RST(RST), .imem_req(w_req), .imem_addr(w_addr),
      .imem_ready(imem_ready), .imem_rdata(w_rdata), .instr(w_instr),
      .instr_valid(w_vld), .exec_done(exec_done), .Branch(zero_l),
      .Jump(zero_l), .Zero(zero_l), .pc(w_pc), .fault(w_fault));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard queues: expected fetch addresses and latched instructions.
   logic [31:0] m_aq[$], m_iq[$], h_aq[$], h_iq[$], w_aq[$], w_iq[$];
   logic [31:0] me, he, we;
   logic m_vld_d = 1'b0, h_vld_d = 1'b0, w_vld_d = 1'b0;

   always @(negedge CLK) begin
      if (!RST && m_req && imem_ready) begin
         if (m_aq.size() == 0) chk("main_unexpected_fetch", m_addr, 32'hDEAD_BEEF);
         else begin me = m_aq.pop_front(); chk("main_fetch_addr", m_addr, me); end
      end
      if (m_vld && !m_vld_d) begin
         if (m_iq.size() == 0) chk("main_unexpected_instr", m_instr, 32'hDEAD_BEEF);
         else begin me = m_iq.pop_front(); chk("main_instr", m_instr, me); end
      end
      m_vld_d = m_vld;
   end

   always @(negedge CLK) begin
      if (!RST && h_req && imem_ready) begin
         if (h_aq.size() == 0) chk("hi_unexpected_fetch", h_addr, 32'hDEAD_BEEF);
         else begin he = h_aq.pop_front(); chk("hi_fetch_addr", h_addr, he); end
      end
      if (h_vld && !h_vld_d) begin
         if (h_iq.size() == 0) chk("hi_unexpected_instr", h_instr, 32'hDEAD_BEEF);
         else begin he = h_iq.pop_front(); chk("hi_instr", h_instr, he); end
      end
      h_vld_d = h_vld;
   end

   always @(negedge CLK) begin
      if (!RST && w_req && imem_ready) begin
         if (w_aq.size() == 0) chk("wrap_unexpected_fetch", w_addr, 32'hDEAD_BEEF);
         else begin we = w_aq.pop_front(); chk("wrap_fetch_addr", w_addr, we); end
      end
      if (w_vld && !w_vld_d) begin
         if (w_iq.size() == 0) chk("wrap_unexpected_instr", w_instr, 32'hDEAD_BEEF);
         else begin we = w_iq.pop_front(); chk("wrap_instr", w_instr, we); end
      end
      w_vld_d = w_vld;
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // One fetch/execute step. am/ah/aw: hand-computed fetch address per unit.
   task automatic step(input logic [31:0] am, ah, aw, input int wt,
                       input bit b, j, z, hjump, spur);
      int n;
      m_aq.push_back(am); m_iq.push_back(mem_word(am));
      h_aq.push_back(ah); h_iq.push_back(mem_word(ah));
      w_aq.push_back(aw); w_iq.push_back(mem_word(aw));
      n = 0;
      while (!m_req && n < 10) begin tick(); n++; end
      if (!m_req) chk("fetch_req_timeout", {31'd0, m_req}, 32'd1);
      for (int k = 0; k < wt; k++) begin
         exec_done = spur && (k == 0);
         chk("wait_req", {31'd0, m_req}, 32'd1);
         chk("wait_addr", m_addr, am);
         chk("wait_fault", {31'd0, m_fault}, 32'd0);
         tick();
      end
      exec_done = 1'b0;
      imem_ready = 1'b1;
      tick();
      imem_ready = 1'b0;
      chk("exec_valid", {31'd0, m_vld}, 32'd1);
      chk("exec_req", {31'd0, m_req}, 32'd0);
      Branch = b; Jump = j; Zero = z; hj = hjump;
      exec_done = 1'b1;
      tick();
      exec_done = 1'b0;
      Branch = 1'b0; Jump = 1'b0; Zero = 1'b0; hj = 1'b0;
   endtask

   initial begin
      // Reset held for two edges.
      RST = 1'b1;
      tick(); tick();
      chk("rst_pc", m_pc, 32'h0000_0000);
      chk("rst_instr", m_instr, 32'h0000_0000);
      chk("rst_req", {31'd0, m_req}, 32'd0);
      chk("rst_valid", {31'd0, m_vld}, 32'd0);
      chk("rst_fault", {31'd0, m_fault}, 32'd0);
      chk("rst_hi_pc", h_pc, 32'h4000_0020);
      chk("rst_wrap_pc", w_pc, 32'hFFFF_FFFC);
      RST = 1'b0;
      chk("idle_req", {31'd0, m_req}, 32'd0);
      tick();

      //        main          hi            wrap          wait B  J  Z  hJ spur
      step(32'h0000_0000, 32'h4000_0020, 32'hFFFF_FFFC, 0, 0, 0, 0, 1, 0);
      step(32'h0000_0004, 32'h4000_0400, 32'h0000_0000, 3, 0, 0, 0, 0, 1);
      step(32'h0000_0008, 32'h4000_0404, 32'h0000_0004, 0, 0, 0, 0, 0, 0);
      step(32'h0000_000C, 32'h4000_0408, 32'h0000_0008, 0, 0, 0, 0, 0, 0);
      step(32'h0000_0010, 32'h4000_040C, 32'h0000_000C, 0, 1, 0, 1, 0, 0);
      step(32'h0000_000C, 32'h4000_0410, 32'h0000_0010, 0, 0, 0, 0, 0, 0);
      step(32'h0000_0010, 32'h4000_0414, 32'h0000_0014, 0, 1, 0, 0, 0, 0);
      step(32'h0000_0014, 32'h4000_0418, 32'h0000_0018, 0, 1, 1, 1, 0, 0);
      step(32'h0000_0100, 32'h4000_041C, 32'h0000_001C, 0, 0, 0, 0, 0, 0);

      // Watchdog: memory never answers.
      repeat (15) tick();
      chk("wd_pre_fault", {31'd0, m_fault}, 32'd0);
      chk("wd_pre_req", {31'd0, m_req}, 32'd1);
      chk("wd_pre_addr", m_addr, 32'h0000_0104);
      tick();
      chk("wd_fault", {31'd0, m_fault}, 32'd1);
      chk("wd_req", {31'd0, m_req}, 32'd0);
      chk("wd_wrap_fault", {31'd0, w_fault}, 32'd1);
      chk("wd_hi_no_fault", {31'd0, h_fault}, 32'd0);
      repeat (984) tick();
      chk("wd_hi_1000_fault", {31'd0, h_fault}, 32'd0);
      chk("wd_hi_1000_req", {31'd0, h_req}, 32'd1);
      chk("wd_sticky_fault", {31'd0, m_fault}, 32'd1);
      chk("wd_sticky_req", {31'd0, m_req}, 32'd0);

      // Late ready: only the watchdog-free unit is still fetching.
      h_aq.push_back(32'h4000_0420); h_iq.push_back(mem_word(32'h4000_0420));
      imem_ready = 1'b1;
      tick();
      imem_ready = 1'b0;
      chk("fault_hold_instr", m_instr, mem_word(32'h0000_0100));
      chk("fault_hold_valid", {31'd0, m_vld}, 32'd0);
      chk("fault_hold_pc", m_pc, 32'h0000_0104);
      chk("fault_hold_flag", {31'd0, m_fault}, 32'd1);
      chk("hi_late_valid", {31'd0, h_vld}, 32'd1);

      // Reset clears the fault and restarts at RESET_PC.
      RST = 1'b1;
      tick();
      chk("rst2_fault", {31'd0, m_fault}, 32'd0);
      chk("rst2_pc", m_pc, 32'h0000_0000);
      chk("rst2_instr", m_instr, 32'h0000_0000);
      chk("rst2_wrap_fault", {31'd0, w_fault}, 32'd0);
      chk("rst2_hi_valid", {31'd0, h_vld}, 32'd0);
      RST = 1'b0;
      tick();
      chk("refetch_req", {31'd0, m_req}, 32'd1);

      // Reset mid-FETCH with a late ready straddling reset and IDLE.
      RST = 1'b1;
      imem_ready = 1'b1;
      tick();
      chk("midrst_req", {31'd0, m_req}, 32'd0);
      RST = 1'b0;
      tick();
      imem_ready = 1'b0;
      chk("midrst_instr", m_instr, 32'h0000_0000);
      chk("midrst_pc", m_pc, 32'h0000_0000);
      chk("midrst_valid", {31'd0, m_vld}, 32'd0);
      chk("midrst_req_fetch", {31'd0, m_req}, 32'd1);

      step(32'h0000_0000, 32'h4000_0020, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0);
      tick();
      chk("drain_main", m_aq.size() + m_iq.size(), 32'd0);
      chk("drain_hi", h_aq.size() + h_iq.size(), 32'd0);
      chk("drain_wrap", w_aq.size() + w_iq.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Hard stop if the sequence wedges.
   initial begin
      #200000;
      $display("FAIL global_timeout: run did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule
